// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN datapath.
//   pe_state_t    - processing-element tile control states
//   DEF_*         - default width constants
//   requant()     - saturating or truncating reduction to a narrower signed width
package cnn_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_TAPS   = 16;
    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned DEF_PACK   = 4;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_CNT_W  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain
    } pe_state_t;

    // Reduce a sign-extended value to i_data_w bits. The result is returned sign-extended
    // to 64 bits; callers keep the low i_data_w bits.
    function automatic logic signed [63:0] requant(input logic signed [63:0] i_val,
                                                   input int unsigned        i_data_w,
                                                   input logic               i_sat);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res;
        max_v = (64'sd1 <<< (i_data_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (i_sat) begin
            if (i_val > max_v) begin
                res = max_v;
            end else if (i_val < min_v) begin
                res = min_v;
            end else begin
                res = i_val;
            end
        end else begin
            // Two's-complement wrap: keep the low bits, re-extend their sign.
            res = (i_val <<< (64 - i_data_w)) >>> (64 - i_data_w);
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate with clear-on-last and requantised output.
// Optional feature macro: PE_SATURATE_EN (saturate instead of truncate on requant).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             a pixel handshake this cycle (accumulate)
//   i_last           this handshake is the window's last tap (clear accumulator)
//   i_pix, i_wgt     signed pixel and weight
//   i_shift          arithmetic right shift applied before requant
//   o_res            requantised (acc + product) >>> shift, valid when i_en && i_last
module conv_mac
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned SHIFT_W = $clog2(DEF_ACC_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_pix,
    input  logic [DATA_W-1:0] i_wgt,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [DATA_W-1:0] o_res
);

`ifdef PE_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic        [2*DATA_W-1:0] w_pix_ext;
    logic        [2*DATA_W-1:0] w_wgt_ext;
    logic        [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [63:0]         w_wide;
    logic signed [ACC_W-1:0]    r_acc;

    // Low 2*DATA_W bits of the product of sign-extended operands equal the signed product.
    assign w_pix_ext  = {{DATA_W{i_pix[DATA_W-1]}}, i_pix};
    assign w_wgt_ext  = {{DATA_W{i_wgt[DATA_W-1]}}, i_wgt};
    assign w_prod     = w_pix_ext * w_wgt_ext;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shifted  = w_sum >>> i_shift;
    assign w_wide     = {{(64-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
    assign o_res      = DATA_W'(requant(w_wide, DATA_W, SAT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

endmodule

// File: rtl/conv_pe_lane.sv
// conv_pe_lane: parametrised convolution PE. Loads a TAPS-weight filter, accumulates one
// output per TAPS pixels, requantises by a runtime shift and packs PACK results per
// output-memory word. Owns the tile FSM (IDLE -> LOAD -> COMPUTE -> DRAIN).
// Optional feature macro: PE_SATURATE_EN (clamp results instead of wrapping).
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_start, i_keep_filter              tile start; reuse stored filter when keep is set
//   i_num_windows, i_base_addr, i_out_shift   tile parameters sampled with start
//   i_filt_valid/o_filt_ready/i_filt_data     filter stream, tap 0 first
//   i_pix_valid/o_pix_ready/i_pix_data        pixel stream
//   o_wr_en, o_wr_addr, o_wr_data       registered output-memory write, lane 0 in LSBs
//   o_busy, o_done                      state != IDLE; one-cycle tile-complete pulse
module conv_pe_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TAPS   = DEF_TAPS,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned PACK   = DEF_PACK,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_keep_filter,
    input  logic [CNT_W-1:0]           i_num_windows,
    input  logic [ADDR_W-1:0]          i_base_addr,
    input  logic [$clog2(ACC_W)-1:0]   i_out_shift,
    input  logic                       i_filt_valid,
    output logic                       o_filt_ready,
    input  logic [DATA_W-1:0]          i_filt_data,
    input  logic                       i_pix_valid,
    output logic                       o_pix_ready,
    input  logic [DATA_W-1:0]          i_pix_data,
    output logic                       o_wr_en,
    output logic [ADDR_W-1:0]          o_wr_addr,
    output logic [PACK*DATA_W-1:0]     o_wr_data,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned SHIFT_W = $clog2(ACC_W);
    localparam int unsigned TAP_W   = $clog2(TAPS);
    localparam int unsigned LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;

    if (TAPS < 2 || ACC_W < 2 * DATA_W + $clog2(TAPS) || ACC_W > 63) begin : g_param_chk
        $error("conv_pe_lane: TAPS must be >= 2 and ACC_W in [2*DATA_W+clog2(TAPS), 63]");
    end

    pe_state_t               r_state;
    logic [TAP_W-1:0]        r_tap_idx;
    logic [CNT_W-1:0]        r_win_cnt;
    logic [CNT_W-1:0]        r_num_win;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       r_word_idx;
    logic [SHIFT_W-1:0]      r_shift;
    logic [LANE_W-1:0]       r_lane_idx;
    logic [PACK*DATA_W-1:0]  r_lanes;
    logic [DATA_W-1:0]       r_weights [TAPS];
    logic                    r_wr_en;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [PACK*DATA_W-1:0]  r_wr_data;
    logic                    r_done;

    logic                    w_pix_hs;
    logic                    w_tap_last;
    logic                    w_lane_last;
    logic                    w_win_last;
    logic [DATA_W-1:0]       w_res;
    logic [PACK*DATA_W-1:0]  w_word;

    assign o_filt_ready = (r_state == StLoad);
    assign o_pix_ready  = (r_state == StCompute);
    assign o_busy       = (r_state != StIdle);
    assign o_done       = r_done;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;

    assign w_pix_hs    = o_pix_ready && i_pix_valid;
    assign w_tap_last  = (r_tap_idx == TAP_W'(TAPS - 1));
    assign w_lane_last = (r_lane_idx == LANE_W'(PACK - 1));
    assign w_win_last  = ((r_win_cnt + CNT_W'(1)) == r_num_win);

    conv_mac #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_pix_hs),
        .i_last  (w_tap_last),
        .i_pix   (i_pix_data),
        .i_wgt   (r_weights[r_tap_idx]),
        .i_shift (r_shift),
        .o_res   (w_res)
    );

    // Current lanes with this window's result dropped into the active lane.
    always_comb begin
        w_word = r_lanes;
        w_word[r_lane_idx*DATA_W +: DATA_W] = w_res;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_tap_idx  <= '0;
            r_win_cnt  <= '0;
            r_num_win  <= '0;
            r_base     <= '0;
            r_word_idx <= '0;
            r_shift    <= '0;
            r_lane_idx <= '0;
            r_lanes    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                r_weights[i] <= '0;
            end
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_win  <= i_num_windows;
                        r_base     <= i_base_addr;
                        r_shift    <= i_out_shift;
                        r_tap_idx  <= '0;
                        r_win_cnt  <= '0;
                        r_word_idx <= '0;
                        r_lane_idx <= '0;
                        r_lanes    <= '0;
                        // An empty tile completes immediately without touching memory.
                        if (i_num_windows == '0) begin
                            r_done <= 1'b1;
                        end else if (i_keep_filter) begin
                            r_state <= StCompute;
                        end else begin
                            r_state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (i_filt_valid) begin
                        r_weights[r_tap_idx] <= i_filt_data;
                        if (w_tap_last) begin
                            r_tap_idx <= '0;
                            r_state   <= StCompute;
                        end else begin
                            r_tap_idx <= r_tap_idx + TAP_W'(1);
                        end
                    end
                end
                StCompute: begin
                    if (i_pix_valid) begin
                        if (w_tap_last) begin
                            r_tap_idx <= '0;
                            r_win_cnt <= r_win_cnt + CNT_W'(1);
                            if (w_lane_last || w_win_last) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= r_base + r_word_idx;
                                r_wr_data  <= w_word;
                                r_word_idx <= r_word_idx + ADDR_W'(1);
                                r_lanes    <= '0;
                                r_lane_idx <= '0;
                            end else begin
                                r_lanes    <= w_word;
                                r_lane_idx <= r_lane_idx + LANE_W'(1);
                            end
                            // done is raised with the final write so both land in DRAIN.
                            if (w_win_last) begin
                                r_state <= StDrain;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_tap_idx <= r_tap_idx + TAP_W'(1);
                        end
                    end
                end
                StDrain: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pe_lane.sv
// Self-checking bench for conv_pe_lane (default parameters). Honours PE_SATURATE_EN.
module tb_conv_pe_lane;

    localparam int DATA_W  = 8;
    localparam int TAPS    = 16;
    localparam int ACC_W   = 24;
    localparam int PACK    = 4;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 10;
    localparam int SHIFT_W = $clog2(ACC_W);

    typedef logic signed [DATA_W-1:0] elem_t;

    typedef struct {
        elem_t       w;
        elem_t       p;
        int          nw;
        int          sh;
        logic [7:0]  base;
        int          nwr;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

`ifdef PE_SATURATE_EN
    localparam logic [7:0] E_MAX   = 8'h7F;
    localparam logic [7:0] E_BIG   = 8'h7F;
    localparam logic [7:0] E_NEG   = 8'h80;
`else
    localparam logic [7:0] E_MAX   = 8'h10;
    localparam logic [7:0] E_BIG   = 8'h00;
    localparam logic [7:0] E_NEG   = 8'h00;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   keep_filter = 1'b0;
    logic [CNT_W-1:0]       num_windows = '0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic [SHIFT_W-1:0]     out_shift = '0;
    logic                   filt_valid = 1'b0;
    logic                   filt_ready;
    logic [DATA_W-1:0]      filt_data = '0;
    logic                   pix_valid = 1'b0;
    logic                   pix_ready;
    logic [DATA_W-1:0]      pix_data = '0;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [PACK*DATA_W-1:0] wr_data;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    conv_pe_lane #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W),
        .PACK   (PACK),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_keep_filter (keep_filter),
        .i_num_windows (num_windows),
        .i_base_addr   (base_addr),
        .i_out_shift   (out_shift),
        .i_filt_valid  (filt_valid),
        .o_filt_ready  (filt_ready),
        .i_filt_data   (filt_data),
        .i_pix_valid   (pix_valid),
        .o_pix_ready   (pix_ready),
        .i_pix_data    (pix_data),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_busy        (busy),
        .o_done        (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge.
    logic [ADDR_W-1:0]      mon_addr[$];
    logic [PACK*DATA_W-1:0] mon_data[$];
    logic [ADDR_W-1:0]      exp_addr[$];
    logic [PACK*DATA_W-1:0] exp_data[$];
    int done_cnt = 0;
    int done_cyc = 0;
    bit done_with_wr = 1'b0;
    bit filt_ready_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_with_wr = wr_en;
        end
        if (filt_ready) filt_ready_seen = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        exp_addr.delete();
        exp_data.delete();
        done_cnt = 0;
        done_with_wr = 1'b0;
        filt_ready_seen = 1'b0;
    endtask

    task automatic do_start(input bit keep, input int nw, input logic [7:0] base, input int sh);
        @(negedge clk);
        start       = 1'b1;
        keep_filter = keep;
        num_windows = CNT_W'(nw);
        base_addr   = base;
        out_shift   = SHIFT_W'(sh);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_filter(input elem_t w[$]);
        int idx = 0;
        int guard = 0;
        bit hs;
        while (idx < w.size() && guard < 2000) begin
            filt_valid = 1'b1;
            filt_data  = w[idx];
            hs = filt_ready;
            @(negedge clk);
            guard++;
            if (hs) idx++;
        end
        filt_valid = 1'b0;
        check("filt_stream_done", 64'(idx), 64'(w.size()));
    endtask

    task automatic feed_pixels(input elem_t px[$], input bit gaps, output int first_cyc);
        int idx = 0;
        int guard = 0;
        bit hs;
        first_cyc = -1;
        while (idx < px.size() && guard < 5000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = px[idx];
            end
            hs = pix_valid && pix_ready;
            if (hs && idx == 0) first_cyc = cyc;
            @(negedge clk);
            guard++;
            if (hs) idx++;
        end
        pix_valid = 1'b0;
        check("pix_stream_done", 64'(idx), 64'(px.size()));
    endtask

    task automatic wait_done(input int n);
        int g = 0;
        #1;
        while (done_cnt < n && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_count"}, 64'(mon_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
            check({tag, "_wr_addr"}, 64'(mon_addr[i]), 64'(exp_addr[i]));
            check({tag, "_wr_data"}, 64'(mon_data[i]), 64'(exp_data[i]));
        end
    endtask

    function automatic logic [7:0] model_res(input int sum, input int sh);
        int v;
        v = sum >>> sh;
`ifdef PE_SATURATE_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`endif
        return v[7:0];
    endfunction

    // Append the expected writes of one tile to exp_addr/exp_data.
    task automatic model_tile(input elem_t w[$], input elem_t px[$], input int nw, input int sh,
                              input logic [7:0] base);
        logic [31:0] word = '0;
        int lane = 0;
        int widx = 0;
        for (int k = 0; k < nw; k++) begin
            int s = 0;
            for (int t = 0; t < TAPS; t++) s += int'(w[t]) * int'(px[k*TAPS+t]);
            word[lane*8 +: 8] = model_res(s, sh);
            if (lane == PACK - 1 || k == nw - 1) begin
                exp_addr.push_back(base + 8'(widx));
                exp_data.push_back(word);
                word = '0;
                lane = 0;
                widx++;
            end else begin
                lane++;
            end
        end
    endtask

    vec_t  tbl[6];
    elem_t wq[$];
    elem_t pq[$];
    elem_t pq2[$];
    int    fc;

    initial begin
        tbl[0] = '{8'sd1, 8'sd2, 1, 0, 8'h10, 1, 32'h0000_0020, 32'h0};
        tbl[1] = '{8'sd1, 8'sd2, 6, 0, 8'h20, 2, 32'h2020_2020, 32'h0000_2020};
        tbl[2] = '{8'sd127, 8'sd127, 1, 0, 8'h30, 1, {24'h0, E_MAX}, 32'h0};
        tbl[3] = '{-8'sd3, 8'sd5, 2, 2, 8'h40, 1, 32'h0000_C4C4, 32'h0};
        tbl[4] = '{-8'sd128, -8'sd128, 1, 10, 8'h50, 1, {24'h0, E_BIG}, 32'h0};
        tbl[5] = '{-8'sd128, 8'sd127, 1, 0, 8'h60, 1, {24'h0, E_NEG}, 32'h0};

        // Reset state.
        #12;
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_wr_addr", 64'(wr_addr), 0);
        check("rst_wr_data", 64'(wr_data), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_filt_ready", 64'(filt_ready), 0);
        check("rst_pix_ready", 64'(pix_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven tiles with uniform weights and pixels.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            wq.delete();
            pq.delete();
            for (int t = 0; t < TAPS; t++) wq.push_back(tbl[v].w);
            for (int i = 0; i < tbl[v].nw * TAPS; i++) pq.push_back(tbl[v].p);
            exp_addr.push_back(tbl[v].base);
            exp_data.push_back(tbl[v].exp0);
            if (tbl[v].nwr == 2) begin
                exp_addr.push_back(tbl[v].base + 8'd1);
                exp_data.push_back(tbl[v].exp1);
            end
            do_start(1'b0, tbl[v].nw, tbl[v].base, tbl[v].sh);
            feed_filter(wq);
            feed_pixels(pq, 1'b0, fc);
            wait_done(1);
            check($sformatf("vec%0d_done_with_wr", v), 64'(done_with_wr), 1);
            repeat (2) @(negedge clk);
            #1;
            check($sformatf("vec%0d_done_cnt", v), 64'(done_cnt), 1);
            check($sformatf("vec%0d_busy_low", v), 64'(busy), 0);
            compare_writes($sformatf("vec%0d", v));
        end

        // Empty tile: done next cycle, no write, never busy.
        clear_mon();
        do_start(1'b0, 0, 8'h70, 0);
        #1;
        check("empty_done", 64'(done), 1);
        check("empty_busy", 64'(busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check("empty_done_cnt", 64'(done_cnt), 1);
        check("empty_no_write", 64'(mon_addr.size()), 0);
        check("empty_no_load", 64'(filt_ready_seen), 0);

        // Random filter, then the same pixels again with keep_filter.
        wq.delete();
        pq.delete();
        for (int t = 0; t < TAPS; t++) wq.push_back(elem_t'($urandom_range(0, 255)));
        for (int i = 0; i < 3 * TAPS; i++) pq.push_back(elem_t'($urandom_range(0, 255)));
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            model_tile(wq, pq, 3, 3, 8'h80);
            do_start(pass == 1, 3, 8'h80, 3);
            if (pass == 0) feed_filter(wq);
            feed_pixels(pq, 1'b0, fc);
            wait_done(1);
            repeat (2) @(negedge clk);
            #1;
            compare_writes($sformatf("keep%0d", pass));
            if (pass == 1) begin
                check("keep_no_filt_ready", 64'(filt_ready_seen), 0);
                check("keep_latency", 64'(done_cyc - fc), 64'(3 * TAPS));
            end
        end

        // Three back-to-back tiles with pixel gaps; addresses wrap past 0xFF.
        clear_mon();
        for (int tile = 0; tile < 3; tile++) begin
            pq2.delete();
            for (int i = 0; i < 10 * TAPS; i++) pq2.push_back(elem_t'($urandom_range(0, 255)));
            model_tile(wq, pq2, 10, 5, 8'hFE);
            do_start(tile != 0, 10, 8'hFE, 5);
            if (tile == 0) feed_filter(wq);
            feed_pixels(pq2, 1'b1, fc);
            wait_done(tile + 1);
        end
        repeat (2) @(negedge clk);
        #1;
        check("b2b_done_cnt", 64'(done_cnt), 3);
        compare_writes("b2b");
        check("b2b_wrap_addr", 64'(mon_addr.size() > 2 ? mon_addr[2] : 8'hAA), 64'h00);

        // Reset mid-COMPUTE: abort, no partial word, then a fresh tile works.
        clear_mon();
        pq.delete();
        for (int i = 0; i < 24; i++) pq.push_back(8'sd9);
        do_start(1'b0, 2, 8'h90, 0);
        feed_filter(wq);
        feed_pixels(pq, 1'b0, fc);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 64'(wr_en), 0);
        check("midrst_wr_addr", 64'(wr_addr), 0);
        check("midrst_wr_data", 64'(wr_data), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_done", 64'(done), 0);
        check("midrst_pix_ready", 64'(pix_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("midrst_no_write", 64'(mon_addr.size()), 0);
        check("midrst_no_done", 64'(done_cnt), 0);

        clear_mon();
        wq.delete();
        pq.delete();
        for (int t = 0; t < TAPS; t++) wq.push_back(8'sd1);
        for (int i = 0; i < TAPS; i++) pq.push_back(8'sd2);
        exp_addr.push_back(8'h10);
        exp_data.push_back(32'h0000_0020);
        do_start(1'b0, 1, 8'h10, 0);
        feed_filter(wq);
        feed_pixels(pq, 1'b0, fc);
        wait_done(1);
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_done_cnt", 64'(done_cnt), 1);
        compare_writes("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
